// File: rtl/video_timing.sv
// ---------------------------------------------------------------------------
// video_timing
//   Raster timing generator for a 2x pixel-rate video clock. A 10-bit
//   horizontal counter (two counts per pixel) and a 9-bit line counter drive
//   the blanking, sync and strobe decodes, a flip-aware line number for the
//   tile/sprite generators, a frame counter and a level-held vblank NMI.
//
// Ports
//   clk            in   video clock (2x pixel rate), sole clock
//   rst_n          in   synchronous active-low reset
//   i_flip_ena     in   screen flip; inverts o_vtiming_f combinationally
//   i_nmi_ena      in   vblank NMI enable; 0 also clears a pending NMI
//   o_htiming      out  [9:0] horizontal count, 0..H_TOTAL-1
//   o_vcount       out  [8:0] unflipped line count, 0..V_TOTAL-1
//   o_vtiming_f    out  [7:0] o_vcount[7:0] XOR {8{i_flip_ena}}
//   o_hblk         out  horizontal blank (o_htiming[9])
//   o_vblk         out  vertical blank (line < 16 or line >= 240)
//   o_cmpblk       out  composite blank; CPU owns VRAM while 1
//   o_hsync_n      out  horizontal sync, low for counts 0x240..0x25F
//   o_vsync_n      out  vertical sync, low for lines 244..251
//   o_pix_ce       out  pixel clock enable (odd counts)
//   o_line_start   out  high while o_htiming == 0
//   o_frame_start  out  high while o_htiming == 0 and o_vcount == 0
//   o_nmi_n        out  active-low vblank interrupt, level-held
//   o_frame_cnt    out  [7:0] frame counter, steps at each frame wrap
// ---------------------------------------------------------------------------
module video_timing #(
  parameter int H_TOTAL = 768,
  parameter int V_TOTAL = 264
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flip_ena,
  input  logic       i_nmi_ena,
  output logic [9:0] o_htiming,
  output logic [8:0] o_vcount,
  output logic [7:0] o_vtiming_f,
  output logic       o_hblk,
  output logic       o_vblk,
  output logic       o_cmpblk,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic       o_pix_ce,
  output logic       o_line_start,
  output logic       o_frame_start,
  output logic       o_nmi_n,
  output logic [7:0] o_frame_cnt
);

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST       = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACT_FIRST  = 9'd16;
  localparam logic [8:0] V_BLANK_FROM = 9'd240;
  localparam logic [8:0] NMI_LINE     = 9'd239;  // last active line
  localparam logic [9:0] HSYNC_FIRST  = 10'h240;
  localparam logic [9:0] HSYNC_LAST   = 10'h25F;
  localparam logic [8:0] VSYNC_FIRST  = 9'd244;
  localparam logic [8:0] VSYNC_LAST   = 9'd251;

  logic [9:0] r_htiming;
  logic [8:0] r_vcount;
  logic [7:0] r_frame_cnt;
  logic       r_nmi_n;

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_nmi_set;
  logic w_vblk;

  assign w_h_wrap  = (r_htiming == H_LAST);
  assign w_v_wrap  = (r_vcount == V_LAST);
  // Set event is the edge that moves the line count from 239 to 240.
  assign w_nmi_set = w_h_wrap && (r_vcount == NMI_LINE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_htiming   <= '0;
      r_vcount    <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_h_wrap) begin
        r_htiming <= '0;
        if (w_v_wrap) begin
          r_vcount    <= '0;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
          r_vcount <= r_vcount + 9'd1;
        end
      end else begin
        r_htiming <= r_htiming + 10'd1;
      end
    end
  end

  // Clear (enable low) has priority over a coincident set event; once low the
  // NMI stays low through the end of vblank until cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_nmi_n <= 1'b1;
    end else if (!i_nmi_ena) begin
      r_nmi_n <= 1'b1;
    end else if (w_nmi_set) begin
      r_nmi_n <= 1'b0;
    end
  end

  // All decodes are purely combinational on the live counters.
  assign w_vblk = (r_vcount < V_ACT_FIRST) || (r_vcount >= V_BLANK_FROM);

  assign o_htiming     = r_htiming;
  assign o_vcount      = r_vcount;
  assign o_vtiming_f   = r_vcount[7:0] ^ {8{i_flip_ena}};
  assign o_hblk        = r_htiming[9];
  assign o_vblk        = w_vblk;
  assign o_cmpblk      = r_htiming[9] | w_vblk;
  assign o_hsync_n     = !((r_htiming >= HSYNC_FIRST) && (r_htiming <= HSYNC_LAST));
  assign o_vsync_n     = !((r_vcount >= VSYNC_FIRST) && (r_vcount <= VSYNC_LAST));
  assign o_pix_ce      = r_htiming[0];
  assign o_line_start  = (r_htiming == 10'd0);
  assign o_frame_start = (r_htiming == 10'd0) && (r_vcount == 9'd0);
  assign o_nmi_n       = r_nmi_n;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 Parameter H_TOTAL, 768, htiming counts per line (two counts per pixel); active 0x000-0x1FF, blanking 0x200-0x2FF.
REQ-002 Parameter V_TOTAL, 264, lines per frame; active lines 16-239 inclusive.
REQ-003 clk  in  1  video clock, twice the pixel rate, sole clock.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 flip_ena  in  1  screen flip from video control register.
REQ-006 nmi_ena  in  1  vblank NMI enable from CPU latch; 0 also clears a pending NMI.
REQ-007 htiming  out  10  horizontal count.
REQ-008 vcount  out  9  unflipped line count, 0 to V_TOTAL-1.
REQ-009 vtiming_f  out  8  vcount[7:0] XOR {8{flip_ena}}, consumed by the tile and sprite generators.
REQ-010 hblk  out  1  horizontal blank, equal to htiming[9].
REQ-011 vblk  out  1  vertical blank, 1 when vcount<16 or vcount>=240.
REQ-012 cmpblk  out  1  composite blank, hblk OR vblk; grants VRAM to the CPU when 1.
REQ-013 hsync_n  out  1  active-low horizontal sync.
REQ-014 vsync_n  out  1  active-low vertical sync.
REQ-015 pix_ce  out  1  pixel clock enable, 1 when htiming[0]==1.
REQ-016 line_start  out  1  one-cycle strobe while htiming==0x000.
REQ-017 frame_start  out  1  one-cycle strobe while htiming==0x000 and vcount==0.
REQ-018 nmi_n  out  1  active-low vblank interrupt to CPU, level-held.
REQ-019 frame_cnt  out  8  frame counter, increments at each frame wrap.

Function
REQ-020 htiming SHALL increment by 1 each clk and wrap from H_TOTAL-1 (0x2FF) to 0x000.
REQ-021 vcount SHALL increment on the same edge that htiming wraps, and only on that edge.
REQ-022 vcount SHALL wrap from V_TOTAL-1 (263) to 0 on the same edge that htiming wraps; frame_cnt SHALL increment modulo 256 on that edge.
REQ-023 vblk, hblk, cmpblk, hsync_n, vsync_n, line_start and frame_start SHALL be decoded from the current counter values with zero cycles of latency relative to htiming and vcount.
REQ-024 hsync_n SHALL be 0 for htiming 0x240-0x25F inclusive, i.e. 32 counts.
REQ-025 vsync_n SHALL be 0 for vcount 244-251 inclusive, i.e. 8 whole lines.
REQ-026 vtiming_f SHALL be combinational on flip_ena; a flip_ena change is visible on vtiming_f in the same cycle.
REQ-027 NMI set event: the clock edge on which vcount changes 239->240.
REQ-028 The set event SHALL drive nmi_n to 0 on that edge if nmi_ena==1; otherwise nmi_n SHALL be unchanged.
REQ-029 While nmi_ena==0, nmi_n SHALL be 1 from the next edge; clear wins over a simultaneous set event.
REQ-030 nmi_n SHALL stay 0 until it is cleared by nmi_ena==0 or by reset; vblank ending SHALL NOT clear it.
REQ-031 Raising nmi_ena while vblk==1 but after the set event SHALL NOT assert nmi_n.
REQ-032 Counter widths: htiming 10 bits and vcount 9 bits; no counter value outside its range SHALL ever be produced.

Reset
REQ-033 While rst_n==0 at a clk edge: htiming=0, vcount=0, frame_cnt=0 and nmi_n=1.
REQ-034 Decoded outputs during and after reset follow REQ-023: vblk=1, cmpblk=1, hblk=0, hsync_n=1, vsync_n=1, line_start=1, frame_start=1.
REQ-035 Reset asserted mid-frame SHALL abandon the frame and restart from 0/0 with no NMI generated.
REQ-036 The first count after reset release SHALL be htiming=0x001.

Verification
REQ-037 Release reset, run 768 clocks -> htiming wraps 0x2FF->0x000, vcount=1, exactly 1 line_start pulse between the wraps, and hsync_n low for exactly 32 clocks beginning at htiming=0x240.
REQ-038 Run 264x768 clocks from reset -> vcount returns to 0, frame_cnt=1, frame_start pulses once, and vsync_n is low for exactly 8x768 clocks.
REQ-039 nmi_ena=1, advance to the 239->240 edge -> nmi_n=0 on that edge; hold to line 16 of the next frame -> nmi_n still 0; drop nmi_ena -> nmi_n=1 one edge later.
REQ-040 nmi_ena=0 on the set edge, then 1 during vblank -> nmi_n stays 1 for the entire frame.
REQ-041 flip_ena toggled at vcount=0x25 -> vtiming_f changes 0x25->0xDA in the same cycle; cmpblk=1 exactly when htiming>=0x200 or vcount is in {0-15, 240-263}.
REQ-042 Assert rst_n=0 at vcount=100, htiming=0x150 for 1 clock -> all counters 0, nmi_n=1, and the following frame timing is identical to the frame after power-on reset.
